// File: rtl/trip_timer.sv
// trip_timer: half-second / one-second timebase and elapsed trip time for
// the bike computer display.
//
// Optional feature macro: TRIP_TIMER_AUTOPAUSE_EN
//   defined   -> time advances only on sec_pulse cycles while moving = 1
//   undefined -> time advances on every sec_pulse; moving is still reported
//
// Parameters
//   HALF_SEC_CYCLES  clock cycles per half second (>= 2)
//   IDLE_SECS        whole seconds without a wheel pulse before moving drops (1..15)
//
// Ports
//   clock           in   system clock, rising edge
//   reset           in   synchronous, active-low
//   wheel_pulse     in   one-cycle pulse per wheel revolution
//   clear           in   one-cycle trip-clear request
//   half_sec_pulse  out  one-cycle pulse every HALF_SEC_CYCLES cycles
//   sec_pulse       out  one-cycle pulse on every second half_sec_pulse
//   moving          out  wheel-activity flag
//   HMS_time        out  [18:12] hours, [11:6] minutes, [5:0] seconds (binary)
//   overflow        out  sticky, set when time saturates at 99:59:59
module trip_timer #(
  parameter int HALF_SEC_CYCLES = 250000,
  parameter int IDLE_SECS       = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        wheel_pulse,
  input  logic        clear,
  output logic        half_sec_pulse,
  output logic        sec_pulse,
  output logic        moving,
  output logic [18:0] HMS_time,
  output logic        overflow
);

  localparam int             PW         = $clog2(HALF_SEC_CYCLES);
  localparam logic [PW-1:0]  PRESC_LAST = PW'(HALF_SEC_CYCLES - 1);
  localparam logic [3:0]     IDLE_LIM   = 4'(IDLE_SECS);

  logic [PW-1:0] presc_q, presc_d;
  logic          phase_q, phase_d;
  logic          half_q,  half_d;
  logic          sec_q,   sec_d;
  logic [3:0]    idle_q,  idle_d;
  logic          mov_q,   mov_d;
  logic [18:0]   hms_q,   hms_d;
  logic          ovf_q,   ovf_d;

  logic          tick;
  logic          adv;
  logic [3:0]    idle_inc;
  logic [6:0]    hh;
  logic [5:0]    mm, ss;
  logic          at_max;

  always_comb begin
    // Prescaler and phase: the pulse cadence is owned by reset alone.
    tick    = (presc_q == PRESC_LAST);
    presc_d = tick ? '0 : presc_q + 1'b1;
    phase_d = phase_q ^ tick;
    half_d  = tick;
    // Second boundary is the half-second tick where phase falls 1 -> 0.
    sec_d   = tick & phase_q;

    // Idle tracking: wheel wins over clear and over the idle increment.
    idle_inc = idle_q + 4'd1;
    idle_d   = idle_q;
    mov_d    = mov_q;
    if (wheel_pulse) begin
      idle_d = 4'd0;
      mov_d  = 1'b1;
    end else if (clear) begin
      idle_d = 4'd0;
    end else if (sec_q && (idle_q != IDLE_LIM)) begin
      idle_d = idle_inc;
      if (idle_inc == IDLE_LIM) mov_d = 1'b0;
    end

    // The gate uses the registered moving flag, so a wheel pulse landing
    // on the sec_pulse cycle does not count for that second.
`ifdef TRIP_TIMER_AUTOPAUSE_EN
    adv = sec_q & mov_q;
`else
    adv = sec_q;
`endif

    hh     = hms_q[18:12];
    mm     = hms_q[11:6];
    ss     = hms_q[5:0];
    at_max = (hh == 7'd99) && (mm == 6'd59) && (ss == 6'd59);

    hms_d = hms_q;
    ovf_d = ovf_q;
    if (clear) begin
      hms_d = '0;
      ovf_d = 1'b0;
    end else if (adv) begin
      if (at_max) begin
        ovf_d = 1'b1;
      end else if (ss != 6'd59) begin
        hms_d[5:0] = ss + 6'd1;
      end else begin
        hms_d[5:0] = 6'd0;
        if (mm != 6'd59) begin
          hms_d[11:6] = mm + 6'd1;
        end else begin
          hms_d[11:6]  = 6'd0;
          hms_d[18:12] = hh + 7'd1;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      presc_q <= '0;
      phase_q <= 1'b0;
      half_q  <= 1'b0;
      sec_q   <= 1'b0;
      idle_q  <= 4'd0;
      mov_q   <= 1'b0;
      hms_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      presc_q <= presc_d;
      phase_q <= phase_d;
      half_q  <= half_d;
      sec_q   <= sec_d;
      idle_q  <= idle_d;
      mov_q   <= mov_d;
      hms_q   <= hms_d;
      ovf_q   <= ovf_d;
    end
  end

  assign half_sec_pulse = half_q;
  assign sec_pulse      = sec_q;
  assign moving         = mov_q;
  assign HMS_time       = hms_q;
  assign overflow       = ovf_q;

endmodule

// File: tb/tb_trip_timer.sv
// Bench for trip_timer: fixed vector table, hand-written corner sequences,
// then randomized stimulus against an integer-seconds reference model.
module tb_trip_timer;

  localparam int H    = 25;
  localparam int IDLE = 3;
  localparam int MAXS = 359999;
`ifdef TRIP_TIMER_AUTOPAUSE_EN
  localparam bit AP = 1'b1;
`else
  localparam bit AP = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        wheel_pulse = 1'b0;
  logic        clear = 1'b0;
  logic        half_sec_pulse, sec_pulse, moving, overflow;
  logic [18:0] HMS_time;

  trip_timer #(.HALF_SEC_CYCLES(H), .IDLE_SECS(IDLE)) dut (
    .clock(clock), .reset(reset), .wheel_pulse(wheel_pulse), .clear(clear),
    .half_sec_pulse(half_sec_pulse), .sec_pulse(sec_pulse), .moving(moving),
    .HMS_time(HMS_time), .overflow(overflow)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: cycles since reset release, elapsed time in seconds.
  int m_t = 0, m_secs = 0, m_idle = 0;
  bit m_half = 0, m_sec = 0, m_mov = 0, m_ovf = 0;

  function automatic logic [18:0] to_hms(input int s);
    logic [6:0] h; logic [5:0] m, x;
    h = 7'(s / 3600); m = 6'((s / 60) % 60); x = 6'(s % 60);
    return {h, m, x};
  endfunction

  function automatic logic [22:0] ex(input logic h, input logic s, input logic m,
                                     input logic o, input logic [18:0] t);
    return {h, s, m, o, t};
  endfunction

  function automatic logic [22:0] dut_out();
    return {half_sec_pulse, sec_pulse, moving, overflow, HMS_time};
  endfunction

  task automatic model_step(input logic w, input logic c, input logic r);
    bit adv;
    if (!r) begin
      m_t = 0; m_secs = 0; m_idle = 0;
      m_half = 0; m_sec = 0; m_mov = 0; m_ovf = 0;
    end else begin
      adv = m_sec && (AP ? m_mov : 1'b1);
      if (c) begin
        m_secs = 0; m_ovf = 0;
      end else if (adv) begin
        if (m_secs == MAXS) m_ovf = 1; else m_secs++;
      end
      if (w) begin
        m_idle = 0; m_mov = 1;
      end else if (c) begin
        m_idle = 0;
      end else if (m_sec) begin
        if (m_idle < IDLE) m_idle++;
        if (m_idle == IDLE) m_mov = 0;
      end
      m_t++;
      m_half = (m_t % H) == 0;
      m_sec  = (m_t % (2 * H)) == 0;
    end
  endtask

  // Called at a negedge; returns at the following negedge.
  task automatic tick(input logic w, input logic c, input logic r);
    wheel_pulse = w; clear = c; reset = r;
    @(posedge clock);
    model_step(w, c, r);
    @(negedge clock);
    wheel_pulse = 1'b0; clear = 1'b0; reset = 1'b1;
  endtask

  task automatic run_to(input int n);
    while (m_t < n) tick(1'b0, 1'b0, 1'b1);
  endtask

  task automatic do_reset();
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
  endtask

  task automatic chk(input string name, input logic [22:0] act, input logic [22:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0d)", name, act, exp, m_t);
    end
  endtask

  task automatic preload(input int s);
    logic [18:0] v;
    v = to_hms(s);
    force dut.hms_q = v;
    #1;
    release dut.hms_q;
    m_secs = s;
  endtask

  typedef struct {
    int          ecyc;
    logic        w;
    logic        c;
    logic [22:0] exp;
  } vec_t;

  vec_t tbl[15];

  initial begin
    // {edge since reset release, wheel, clear, {half,sec,moving,ovf,HMS}}
    tbl[0]  = '{1,   1'b0, 1'b0, ex(0, 0, 0, 0, 19'd0)};
    tbl[1]  = '{10,  1'b1, 1'b0, ex(0, 0, 1, 0, 19'd0)};
    tbl[2]  = '{24,  1'b0, 1'b0, ex(0, 0, 1, 0, 19'd0)};
    tbl[3]  = '{25,  1'b0, 1'b0, ex(1, 0, 1, 0, 19'd0)};
    tbl[4]  = '{26,  1'b0, 1'b0, ex(0, 0, 1, 0, 19'd0)};
    tbl[5]  = '{50,  1'b0, 1'b0, ex(1, 1, 1, 0, 19'd0)};
    tbl[6]  = '{51,  1'b0, 1'b0, ex(0, 0, 1, 0, 19'd1)};
    tbl[7]  = '{100, 1'b0, 1'b0, ex(1, 1, 1, 0, 19'd1)};
    tbl[8]  = '{101, 1'b0, 1'b0, ex(0, 0, 1, 0, 19'd2)};
    tbl[9]  = '{150, 1'b0, 1'b0, ex(1, 1, 1, 0, 19'd2)};
    tbl[10] = '{151, 1'b0, 1'b0, ex(0, 0, 0, 0, 19'd3)};
    tbl[11] = '{201, 1'b0, 1'b0, ex(0, 0, 0, 0, AP ? 19'd3 : 19'd4)};
    tbl[12] = '{251, 1'b0, 1'b0, ex(0, 0, 0, 0, AP ? 19'd3 : 19'd5)};
    tbl[13] = '{260, 1'b1, 1'b0, ex(0, 0, 1, 0, AP ? 19'd3 : 19'd5)};
    tbl[14] = '{301, 1'b0, 1'b0, ex(0, 0, 1, 0, AP ? 19'd4 : 19'd6)};

    @(negedge clock);
    do_reset();
    chk("reset_state", dut_out(), 23'd0);

    foreach (tbl[i]) begin
      run_to(tbl[i].ecyc - 1);
      tick(tbl[i].w, tbl[i].c, 1'b1);
      chk($sformatf("tbl[%0d]", i), dut_out(), tbl[i].exp);
    end

    // Carry 00:59:59 -> 01:00:00, then saturation and clear.
    do_reset();
    run_to(4);  tick(1'b1, 1'b0, 1'b1);
    run_to(45); preload(3599);
    run_to(51); chk("carry_hour", {4'd0, HMS_time}, {4'd0, to_hms(3600)});
    run_to(60); preload(MAXS);
    run_to(89); tick(1'b1, 1'b0, 1'b1);
    run_to(100); chk("ovf_before", {22'd0, overflow}, 23'd0);
    run_to(101); chk("saturate", {overflow, 3'd0, HMS_time}, {1'b1, 3'd0, to_hms(MAXS)});
    run_to(109); tick(1'b0, 1'b1, 1'b1);
    chk("clear_sat", {overflow, 3'd0, HMS_time}, 23'd0);

    // Clear on a sec_pulse cycle: value zeroed, cadence untouched.
    run_to(150); chk("sec_pre_clear", {22'd0, sec_pulse}, 23'd1);
    tick(1'b0, 1'b1, 1'b1);
    chk("clear_on_sec", {4'd0, HMS_time}, 23'd0);
    run_to(199); chk("no_sec_199", {21'd0, half_sec_pulse, sec_pulse}, 23'd0);
    run_to(200); chk("sec_200", {21'd0, half_sec_pulse, sec_pulse}, 23'd3);
    run_to(201); chk("count_after_clear", {4'd0, HMS_time}, 23'd1);

    // Wheel pulse on the idle terminal sec_pulse keeps moving high.
    run_to(300); chk("sec_300", {21'd0, sec_pulse, moving}, 23'd3);
    tick(1'b1, 1'b0, 1'b1);
    chk("wheel_on_idle_term", {moving, 3'd0, HMS_time}, {1'b1, 3'd0, 19'd3});
    run_to(351); chk("still_moving", {moving, 3'd0, HMS_time}, {1'b1, 3'd0, 19'd4});

    // Reset mid-prescale, then cadence restarts from zero.
    run_to(362); tick(1'b0, 1'b0, 1'b0);
    chk("reset_mid", dut_out(), 23'd0);
    run_to(24); chk("restart_24", {21'd0, half_sec_pulse, sec_pulse}, 23'd0);
    run_to(25); chk("restart_25", {21'd0, half_sec_pulse, sec_pulse}, 23'd2);
    run_to(50); chk("restart_50", {21'd0, half_sec_pulse, sec_pulse}, 23'd3);

    // Randomized run against the reference model.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      logic w, c, r;
      w = ($urandom_range(0, 59) == 0);
      c = ($urandom_range(0, 499) == 0);
      r = !($urandom_range(0, 2499) == 0);
      if (i % 600 == 0) preload((i % 1200 == 0) ? MAXS - $urandom_range(0, 3)
                                                : $urandom_range(0, MAXS));
      tick(w, c, r);
      chk("rand", dut_out(),
          ex(m_half, m_sec, m_mov, m_ovf, to_hms(m_secs)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
